// File: rtl/apu_pkg.sv
// Shared frame-sequencer definitions: step type, strobe-mask table and named step constants.
package apu_pkg;

    localparam int FS_STEPS = 8;

    typedef logic [2:0] fs_step_t;

    localparam fs_step_t       FS_ENV_STEP    = 3'd7;
    localparam logic [7:0]     FS_SWEEP_STEPS = 8'b0100_0100;

    // Bits {env, sweep, len} per executed step; entry 7 is the leftmost element.
    localparam logic [FS_STEPS-1:0][2:0] FS_STRB_MASK = {
        3'b100,  // step 7
        3'b011,  // step 6
        3'b000,  // step 5
        3'b001,  // step 4
        3'b000,  // step 3
        3'b011,  // step 2
        3'b000,  // step 1
        3'b001   // step 0
    };

    function automatic logic [2:0] fs_strobe_mask(input fs_step_t s);
        return FS_STRB_MASK[s];
    endfunction

endpackage

// File: rtl/apu_tick_prescaler.sv
// Produces the single-cycle 512 Hz step event, either from an internal DIV_COUNT
// prescaler or, with FS_EXT_DIV_EN defined, from falling edges of the timer DIV bit.
module apu_tick_prescaler #(
    parameter int DIV_COUNT = 32768
) (
    input  logic clock,
    input  logic reset,
    input  logic apu_en,
    input  logic div_bit,
    output logic step_event
);

`ifdef FS_EXT_DIV_EN
    // History flop follows div_bit even while disabled so enabling cannot fake an edge.
    logic div_q_p0;
    localparam int DIV_COUNT_UNUSED = DIV_COUNT;

    always_ff @(posedge clock) begin
        if (!reset) div_q_p0 <= 1'b0;
        else        div_q_p0 <= div_bit;
    end

    assign step_event = apu_en & div_q_p0 & ~div_bit;
`else
    localparam int                CNT_W = $clog2(DIV_COUNT);
    localparam logic [CNT_W-1:0]  TC    = CNT_W'(DIV_COUNT - 1);

    logic [CNT_W-1:0] cnt_p0;
    logic             tc_p0;
    logic             div_unused;

    assign div_unused = div_bit;
    assign tc_p0      = (cnt_p0 == TC);

    always_ff @(posedge clock) begin
        if (!reset || !apu_en) cnt_p0 <= '0;
        else if (tc_p0)        cnt_p0 <= '0;
        else                   cnt_p0 <= cnt_p0 + CNT_W'(1);
    end

    assign step_event = apu_en & tc_p0;
`endif

endmodule

// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: 8-step counter emitting registered len/sweep/env/step strobes.
// Build option: define FS_EXT_DIV_EN to step from div_bit falling edges instead of DIV_COUNT.
module apu_frame_sequencer
    import apu_pkg::*;
#(
    parameter int DIV_COUNT = 32768,
    parameter int STEP_W    = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              apu_en,
    input  logic              div_bit,
    output logic [STEP_W-1:0] step,
    output logic              len_tick,
    output logic              sweep_tick,
    output logic              env_tick,
    output logic              step_tick
);

    logic     vld_p0;
    fs_step_t step_p0;
    logic [2:0] strb_p1;
    logic     vld_p1;

    apu_tick_prescaler #(
        .DIV_COUNT (DIV_COUNT)
    ) u_prescaler (
        .clock      (clock),
        .reset      (reset),
        .apu_en     (apu_en),
        .div_bit    (div_bit),
        .step_event (vld_p0)
    );

    // p0 -> p1: execute the current step and register its strobes
    always_ff @(posedge clock) begin
        if (!reset || !apu_en) begin
            step_p0 <= '0;
            strb_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1  <= vld_p0;
            strb_p1 <= vld_p0 ? fs_strobe_mask(step_p0) : 3'b000;
            if (vld_p0) step_p0 <= step_p0 + 3'd1;
        end
    end

    assign step       = step_p0;
    assign len_tick   = strb_p1[0];
    assign sweep_tick = strb_p1[1];
    assign env_tick   = strb_p1[2];
    assign step_tick  = vld_p1;

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Randomized self-checking bench for apu_frame_sequencer against a step-count reference model.
module tb_apu_frame_sequencer;

    localparam int D = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       apu_en = 1'b0;
    logic       div_bit = 1'b0;
    logic [2:0] step;
    logic       len_tick, sweep_tick, env_tick, step_tick;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: enabled-edge count, executed-step count, expected outputs
    int         n_en = 0;
    int         ev_cnt = 0;
    logic       prev_div = 1'b0;
    logic [2:0] e_step = 3'd0;
    logic       e_len = 1'b0, e_sweep = 1'b0, e_env = 1'b0, e_stk = 1'b0;

    apu_frame_sequencer #(.DIV_COUNT(D), .STEP_W(3)) dut (
        .clock      (clock),
        .reset      (reset),
        .apu_en     (apu_en),
        .div_bit    (div_bit),
        .step       (step),
        .len_tick   (len_tick),
        .sweep_tick (sweep_tick),
        .env_tick   (env_tick),
        .step_tick  (step_tick)
    );

    initial forever #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Advance one clock edge, update the model from the inputs sampled at it, settle.
    task automatic tick();
        bit ev;
        int s;
        @(posedge clock);
        ev = 1'b0;
`ifdef FS_EXT_DIV_EN
        ev       = reset && apu_en && prev_div && !div_bit;
        prev_div = reset ? div_bit : 1'b0;
`else
        if (reset && apu_en) begin
            n_en++;
            ev = (n_en % D == 0);
        end
`endif
        if (!reset || !apu_en) begin
            n_en = 0; ev_cnt = 0; e_step = 3'd0;
            e_len = 1'b0; e_sweep = 1'b0; e_env = 1'b0; e_stk = 1'b0;
        end else begin
            e_len = 1'b0; e_sweep = 1'b0; e_env = 1'b0; e_stk = ev;
            if (ev) begin
                s       = ev_cnt % 8;
                e_len   = (s % 2 == 0);
                e_sweep = (s == 2 || s == 6);
                e_env   = (s == 7);
                ev_cnt++;
            end
            e_step = 3'(ev_cnt % 8);
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; apu_en = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({step, len_tick, sweep_tick, env_tick, step_tick} !== 7'b000_0000) begin
            n_bad++;
            $display("FAIL reset_state got=%b exp=%b", {step, len_tick, sweep_tick, env_tick, step_tick}, 7'b0);
        end
        reset = 1'b1; apu_en = 1'b0;
        tick();
    endtask

    task automatic test_frames();
        int c_len = 0, c_sw = 0, c_env = 0, c_stk = 0, first = -1;
        apu_en = 1'b1;
        for (int i = 1; i <= 3 * 8 * D; i++) begin
            tick();
            n_cmp++;
            if ({step, len_tick, sweep_tick, env_tick, step_tick} !== {e_step, e_len, e_sweep, e_env, e_stk}) begin
                n_bad++;
                $display("FAIL frames cyc=%0d got=%b exp=%b", i,
                         {step, len_tick, sweep_tick, env_tick, step_tick}, {e_step, e_len, e_sweep, e_env, e_stk});
            end
            if (step_tick && first < 0) first = i;
            c_len += int'(len_tick); c_sw += int'(sweep_tick);
            c_env += int'(env_tick); c_stk += int'(step_tick);
        end
        n_cmp++;
        if (first !== D) begin n_bad++; $display("FAIL first_step_tick got=%0d exp=%0d", first, D); end
        n_cmp++;
        if ({c_len, c_sw, c_env, c_stk} !== {32'd12, 32'd6, 32'd3, 32'd24}) begin
            n_bad++;
            $display("FAIL frame_counts got len=%0d sweep=%0d env=%0d step=%0d exp 12/6/3/24", c_len, c_sw, c_env, c_stk);
        end
        apu_en = 1'b0;
        tick();
    endtask

    task automatic test_drop_enable();
        int env_at = -1;
        apu_en = 1'b1;
        for (int i = 0; i < 3 * D + 5; i++) tick();
        n_cmp++;
        if (step !== 3'd3) begin n_bad++; $display("FAIL drop_pre_step got=%0d exp=3", step); end
        apu_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if ({step, len_tick, sweep_tick, env_tick, step_tick} !== 7'b000_0000) begin
                n_bad++;
                $display("FAIL drop_idle cyc=%0d got=%b exp=%b", i, {step, len_tick, sweep_tick, env_tick, step_tick}, 7'b0);
            end
        end
        apu_en = 1'b1;
        for (int i = 1; i <= 100 && env_at < 0; i++) begin
            tick();
            n_cmp++;
            if ({step, len_tick, sweep_tick, env_tick, step_tick} !== {e_step, e_len, e_sweep, e_env, e_stk}) begin
                n_bad++;
                $display("FAIL drop_resume cyc=%0d got=%b exp=%b", i,
                         {step, len_tick, sweep_tick, env_tick, step_tick}, {e_step, e_len, e_sweep, e_env, e_stk});
            end
            if (env_tick) env_at = i;
        end
        n_cmp++;
        if (env_at !== 8 * D) begin n_bad++; $display("FAIL drop_env_latency got=%0d exp=%0d", env_at, 8 * D); end
        apu_en = 1'b0;
        tick();
    endtask

    task automatic test_tc_drop();
        apu_en = 1'b1;
        for (int i = 0; i < D - 1; i++) tick();
        apu_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({step, len_tick, sweep_tick, env_tick, step_tick} !== 7'b000_0000) begin
                n_bad++;
                $display("FAIL tc_drop cyc=%0d got=%b exp=%b", i, {step, len_tick, sweep_tick, env_tick, step_tick}, 7'b0);
            end
        end
    endtask

    task automatic test_mid_reset();
        apu_en = 1'b1;
        for (int i = 0; i < 2 * D + 3; i++) tick();
        reset = 1'b0;
        tick();
        n_cmp++;
        if ({step, len_tick, sweep_tick, env_tick, step_tick} !== 7'b000_0000) begin
            n_bad++;
            $display("FAIL mid_reset got=%b exp=%b", {step, len_tick, sweep_tick, env_tick, step_tick}, 7'b0);
        end
        reset = 1'b1;
        for (int i = 1; i <= 2 * D; i++) begin
            tick();
            n_cmp++;
            if ({step, len_tick, sweep_tick, env_tick, step_tick} !== {e_step, e_len, e_sweep, e_env, e_stk}) begin
                n_bad++;
                $display("FAIL mid_reset_resume cyc=%0d got=%b exp=%b", i,
                         {step, len_tick, sweep_tick, env_tick, step_tick}, {e_step, e_len, e_sweep, e_env, e_stk});
            end
        end
        apu_en = 1'b0;
        tick();
    endtask

    task automatic test_div_bit();
        apu_en = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            if (i % 5 == 0) div_bit = ~div_bit;
            apu_en = !(i >= 120 && i < 140);
            tick();
            n_cmp++;
            if ({step, len_tick, sweep_tick, env_tick, step_tick} !== {e_step, e_len, e_sweep, e_env, e_stk}) begin
                n_bad++;
                $display("FAIL div_bit cyc=%0d got=%b exp=%b", i,
                         {step, len_tick, sweep_tick, env_tick, step_tick}, {e_step, e_len, e_sweep, e_env, e_stk});
            end
        end
        apu_en = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic prev_stk = 1'b0;
        for (int i = 1; i <= 2000; i++) begin
            apu_en  = ($urandom_range(0, 31) != 0);
            reset   = ($urandom_range(0, 199) != 0);
            div_bit = ($urandom_range(0, 3) == 0) ? ~div_bit : div_bit;
            tick();
            n_cmp++;
            if ({step, len_tick, sweep_tick, env_tick, step_tick} !== {e_step, e_len, e_sweep, e_env, e_stk}) begin
                n_bad++;
                $display("FAIL random cyc=%0d got=%b exp=%b", i,
                         {step, len_tick, sweep_tick, env_tick, step_tick}, {e_step, e_len, e_sweep, e_env, e_stk});
            end
            n_cmp++;
            if (prev_stk && step_tick) begin
                n_bad++;
                $display("FAIL back_to_back cyc=%0d got=1 exp=0", i);
            end
            prev_stk = step_tick;
        end
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
`ifndef FS_EXT_DIV_EN
        test_frames();
        test_drop_enable();
        test_tc_drop();
        test_mid_reset();
`endif
        test_div_bit();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
